// File: rtl/lite_nasti_arb_pkg.sv
// Shared types and helpers for the lite NASTI read arbiter.
package lite_nasti_arb_pkg;

  // Largest master count the round-robin helper can search.
  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  // Result of a round-robin search: {found, index}.
  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // Width of the master-index field appended to the upstream ID.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must hold 0..max_out inclusive.
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  // First requester at or after ptr, wrapping at n-1 -> 0.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int n);
    rr_pick_t          res;
    logic [RR_IDX_W:0] j;
    res = '0;
    for (int off = 0; off < RR_MAX_N; off++) begin
      if (off < n && !res.found) begin
        j = {1'b0, ptr} + (RR_IDX_W+1)'(off);
        if (j >= (RR_IDX_W+1)'(n)) j = j - (RR_IDX_W+1)'(n);
        if (req[j[RR_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/lite_nasti_read_arbiter_rr.sv
// Round-robin grant generator; the priority pointer moves past the winner
// only when the caller reports that the grant was actually taken.
module rr_arbiter
  import lite_nasti_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] w_ptr_next;
  rr_pick_t      w_pick;

  // Search for the winner and the pointer value that follows it.
  always_comb begin
    w_pick     = rr_pick(RR_MAX_N'(req), RR_IDX_W'(r_rr_ptr), N);
    w_ptr_next = (int'(w_pick.idx) >= N - 1) ? '0 : IW'(int'(w_pick.idx) + 1);
  end

  assign grant_valid = w_pick.found;
  assign grant_idx   = w_pick.idx[IW-1:0];

  // Advance the pointer past the winner on an accepted grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (adv && grant_valid) begin
      r_rr_ptr <= w_ptr_next;
    end
  end

endmodule

// File: rtl/lite_nasti_read_arbiter.sv
// Shares one NASTI-lite read port among several lite read masters: a
// registered AR slot tagged with the master index, a per-master outstanding
// limit, and a combinational R demux keyed on that index.
module lite_nasti_read_arbiter
  import lite_nasti_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int ID_WIDTH        = 1,
  parameter int IDX_WIDTH       = idx_width(NUM_MASTERS),
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]    s_ar_id,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]  s_ar_addr,
  input  logic [NUM_MASTERS-1:0][2:0]             s_ar_prot,
  input  logic [NUM_MASTERS-1:0][3:0]             s_ar_qos,
  input  logic [NUM_MASTERS-1:0][3:0]             s_ar_region,
  input  logic [NUM_MASTERS-1:0][USER_WIDTH-1:0]  s_ar_user,
  input  logic [NUM_MASTERS-1:0]                  s_ar_valid,
  output logic [NUM_MASTERS-1:0]                  s_ar_ready,
  output logic [NUM_MASTERS-1:0][ID_WIDTH-1:0]    s_r_id,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]  s_r_data,
  output logic [NUM_MASTERS-1:0][1:0]             s_r_resp,
  output logic [NUM_MASTERS-1:0][USER_WIDTH-1:0]  s_r_user,
  output logic [NUM_MASTERS-1:0]                  s_r_valid,
  input  logic [NUM_MASTERS-1:0]                  s_r_ready,
  output logic [IDX_WIDTH+ID_WIDTH-1:0]           m_ar_id,
  output logic [ADDR_WIDTH-1:0]                   m_ar_addr,
  output logic [2:0]                              m_ar_prot,
  output logic [3:0]                              m_ar_qos,
  output logic [3:0]                              m_ar_region,
  output logic [USER_WIDTH-1:0]                   m_ar_user,
  output logic                                    m_ar_valid,
  input  logic                                    m_ar_ready,
  input  logic [IDX_WIDTH+ID_WIDTH-1:0]           m_r_id,
  input  logic [DATA_WIDTH-1:0]                   m_r_data,
  input  logic [1:0]                              m_r_resp,
  input  logic [USER_WIDTH-1:0]                   m_r_user,
  input  logic                                    m_r_valid,
  output logic                                    m_r_ready,
  output logic                                    err_bad_idx
);

  localparam int             CW      = cnt_width(MAX_OUTSTANDING);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTSTANDING);

  // AR slot
  logic                          r_ar_valid;
  logic [IDX_WIDTH+ID_WIDTH-1:0] r_ar_id;
  logic [ADDR_WIDTH-1:0]         r_ar_addr;
  logic [2:0]                    r_ar_prot;
  logic [3:0]                    r_ar_qos;
  logic [3:0]                    r_ar_region;
  logic [USER_WIDTH-1:0]         r_ar_user;

  // Arbitration
  logic                   w_load_ok;
  logic                   w_grant_valid;
  logic [IDX_WIDTH-1:0]   w_grant_idx;
  logic                   w_ar_hs;
  logic [NUM_MASTERS-1:0] w_eligible;
  logic [ID_WIDTH-1:0]    w_sel_id;
  logic [ADDR_WIDTH-1:0]  w_sel_addr;
  logic [2:0]             w_sel_prot;
  logic [3:0]             w_sel_qos;
  logic [3:0]             w_sel_region;
  logic [USER_WIDTH-1:0]  w_sel_user;

  // Outstanding counters
  logic [NUM_MASTERS-1:0][CW-1:0] r_cnt;
  logic [NUM_MASTERS-1:0][CW-1:0] w_cnt_next;
  logic [NUM_MASTERS-1:0]         w_inc;
  logic [NUM_MASTERS-1:0]         w_dec;

  // R routing
  logic [IDX_WIDTH-1:0] w_r_idx;
  logic                 w_bad_idx;

  // The slot accepts a new request when empty or draining this cycle; reset
  // blocks every handshake so nothing is accepted into a discarded slot.
  assign w_load_ok = !r_ar_valid || m_ar_ready;
  assign w_ar_hs   = w_load_ok && w_grant_valid && !rst;

  rr_arbiter #(
    .N(NUM_MASTERS)
  ) u_rr (
    .clk        (clk),
    .rst        (rst),
    .req        (w_eligible),
    .adv        (w_ar_hs),
    .grant_valid(w_grant_valid),
    .grant_idx  (w_grant_idx)
  );

  assign w_r_idx   = m_r_id[ID_WIDTH+IDX_WIDTH-1:ID_WIDTH];
  assign w_bad_idx = (int'(w_r_idx) >= NUM_MASTERS);

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
      assign w_eligible[gi] = s_ar_valid[gi] && (r_cnt[gi] < CNT_MAX);
      assign s_ar_ready[gi] = w_ar_hs && (w_grant_idx == IDX_WIDTH'(gi));
      assign w_inc[gi]      = s_ar_ready[gi];
      // The nonzero guard keeps a stray response from wrapping the counter.
      assign w_dec[gi]      = s_r_valid[gi] && s_r_ready[gi] && (r_cnt[gi] != '0);
      assign w_cnt_next[gi] = (w_inc[gi] && !w_dec[gi]) ? r_cnt[gi] + 1'b1 :
                              (!w_inc[gi] && w_dec[gi]) ? r_cnt[gi] - 1'b1 :
                                                          r_cnt[gi];

      assign s_r_valid[gi]  = m_r_valid && (w_r_idx == IDX_WIDTH'(gi));
      assign s_r_id[gi]     = m_r_id[ID_WIDTH-1:0];
      assign s_r_data[gi]   = m_r_data;
      assign s_r_resp[gi]   = m_r_resp;
      assign s_r_user[gi]   = m_r_user;
    end
  endgenerate

  // Select the granted master's AR payload.
  always_comb begin
    w_sel_id     = '0;
    w_sel_addr   = '0;
    w_sel_prot   = '0;
    w_sel_qos    = '0;
    w_sel_region = '0;
    w_sel_user   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_grant_idx == IDX_WIDTH'(i)) begin
        w_sel_id     = s_ar_id[i];
        w_sel_addr   = s_ar_addr[i];
        w_sel_prot   = s_ar_prot[i];
        w_sel_qos    = s_ar_qos[i];
        w_sel_region = s_ar_region[i];
        w_sel_user   = s_ar_user[i];
      end
    end
  end

  // Route R ready back from the addressed master; unknown indices are drained.
  always_comb begin
    m_r_ready = w_bad_idx;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_r_idx == IDX_WIDTH'(i)) m_r_ready = s_r_ready[i];
    end
  end

  assign err_bad_idx = m_r_valid && w_bad_idx && !rst;

  // Slot valid: set on a handshake, cleared when drained with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ar_valid <= 1'b0;
    end else if (w_load_ok) begin
      r_ar_valid <= w_ar_hs;
    end
  end

  // Slot payload: only written on a handshake, so it holds under backpressure.
  always_ff @(posedge clk) begin
    if (w_ar_hs) begin
      r_ar_id     <= {w_grant_idx, w_sel_id};
      r_ar_addr   <= w_sel_addr;
      r_ar_prot   <= w_sel_prot;
      r_ar_qos    <= w_sel_qos;
      r_ar_region <= w_sel_region;
      r_ar_user   <= w_sel_user;
    end
  end

  // Per-master outstanding-read counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_next;
    end
  end

  assign m_ar_valid  = r_ar_valid;
  assign m_ar_id     = r_ar_id;
  assign m_ar_addr   = r_ar_addr;
  assign m_ar_prot   = r_ar_prot;
  assign m_ar_qos    = r_ar_qos;
  assign m_ar_region = r_ar_region;
  assign m_ar_user   = r_ar_user;

endmodule
